// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the pwm8 control slice: FSM encodings and PWM period geometry.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RAMP  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [7:0] PWM_MAX    = 8'hFF;
    localparam int         PWM_PERIOD = 256;
    localparam int         CNT_W      = $clog2(PWM_PERIOD);

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter with end-of-period decode; shared with pwm8 so both stay in lockstep.
module pwm_period_cnt
    import pwm_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cntr,
    output logic             period_end
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr <= '0;
        end else begin
            cntr <= cntr + 1'b1;
        end
    end

    assign period_end = (cntr == PWM_MAX);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start duty scheduler: slews duty toward a commanded target on PWM period boundaries,
// with an emergency stop that forces duty to zero immediately.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP_W           = 4,
    parameter int PERIODS_PER_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              estop,
    output logic [7:0]        duty,
    output logic              period_end,
    output logic              busy,
    output logic              at_target,
    output logic              fault
);

    localparam logic [7:0] PPS_LAST = 8'(PERIODS_PER_STEP - 1);

    state_t            state;
    logic [7:0]        target;
    logic [STEP_W-1:0] step;
    logic [7:0]        prescale;
    logic [7:0]        next_duty;
    logic              accept;
    logic [CNT_W-1:0]  cntr_unused;

    // Saturating move toward tgt by at most stp; the 9-bit signed difference cannot wrap.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt,
                                               input logic [STEP_W-1:0] stp);
        logic signed [8:0] diff;
        logic signed [8:0] mag;
        logic signed [8:0] inc;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[8] ? -diff : diff;
        inc  = $signed({{(9-STEP_W){1'b0}}, stp});
        if (mag <= inc)
            step_toward = tgt;
        else if (!diff[8])
            step_toward = cur + inc[7:0];
        else
            step_toward = cur - inc[7:0];
    endfunction

    pwm_period_cnt u_period_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .cntr       (cntr_unused),
        .period_end (period_end)
    );

    assign accept    = cmd_valid & cmd_ready;
    assign next_duty = step_toward(duty, target, step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            duty      <= '0;
            target    <= '0;
            step      <= STEP_W'(1);
            prescale  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            at_target <= 1'b1;
            fault     <= 1'b0;
        end else if (estop) begin
            state     <= ST_FAULT;
            duty      <= '0;
            target    <= '0;
            prescale  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            at_target <= 1'b0;
            fault     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target   <= cmd_target;
                        step     <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
                        prescale <= '0;
                        if (cmd_target != duty) begin
                            state     <= ST_RAMP;
                            busy      <= 1'b1;
                            at_target <= 1'b0;
                        end
                    end
                end
                ST_RAMP: begin
                    // A fresh command takes precedence over a step due on the same edge.
                    if (accept) begin
                        target   <= cmd_target;
                        step     <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
                        prescale <= '0;
                        if (cmd_target == duty) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            at_target <= 1'b1;
                        end
                    end else if (period_end) begin
                        if (prescale == PPS_LAST) begin
                            prescale <= '0;
                            duty     <= next_duty;
                            if (next_duty == target) begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                at_target <= 1'b1;
                            end
                        end else begin
                            prescale <= prescale + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    at_target <= 1'b1;
                    fault     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: scoreboarded duty sequences, boundary and estop/reset scenarios.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       estop = 1'b0;
    logic [7:0] cmd_target = 8'h00;
    logic [3:0] cmd_step = 4'h0;

    logic       cmd_ready, period_end, busy, at_target, fault;
    logic [7:0] duty;
    logic       cmd_ready3, period_end3, busy3, at_target3, fault3;
    logic [7:0] duty3;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         mdl_duty = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.STEP_W(4), .PERIODS_PER_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .estop(estop), .duty(duty),
        .period_end(period_end), .busy(busy), .at_target(at_target), .fault(fault)
    );

    pwm_ramp_ctrl #(.STEP_W(4), .PERIODS_PER_STEP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .estop(estop), .duty(duty3),
        .period_end(period_end3), .busy(busy3), .at_target(at_target3), .fault(fault3)
    );

    // Duty may only move on an edge where period_end (or estop) was high beforehand.
    always @(posedge clk) begin : boundary_mon
        logic [7:0] d_before;
        logic       pe_b, es_b, rs_b;
        d_before = duty;
        pe_b     = period_end;
        es_b     = estop;
        rs_b     = rst_n;
        #1;
        if (rs_b && rst_n && duty !== d_before) begin
            vectors++;
            if (!pe_b && !es_b) begin
                $display("FAIL off_boundary: duty %h -> %h without period_end", d_before, duty);
                miscompares++;
            end
        end
    end

    function automatic int model_step(int d, int t, int s);
        int s1;
        s1 = (s == 0) ? 1 : s;
        if (t > d) return (t - d <= s1) ? t : d + s1;
        if (t < d) return (d - t <= s1) ? t : d - s1;
        return d;
    endfunction

    task automatic push_ramp(input int t, input int s);
        int d;
        d = mdl_duty;
        while (d != t) begin
            d = model_step(d, t, s);
            exp_q.push_back(8'(d));
        end
    endtask

    task automatic issue(input logic [7:0] t, input logic [3:0] s);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_step   = s;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic drain(input int n, input int limit);
        logic [7:0] expv, last;
        int cyc;
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            expv = exp_q.pop_front();
            last = duty;
            cyc  = 0;
            while (duty === last && cyc < limit) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            vectors++;
            if (duty === last) begin
                $display("FAIL duty_timeout: duty stuck at %h, expected %h", duty, expv);
                miscompares++;
            end else if (duty !== expv) begin
                $display("FAIL duty_step: got %h expected %h", duty, expv);
                miscompares++;
            end
            mdl_duty = expv;
        end
    endtask

    task automatic check_idle(input string name, input logic [7:0] expd);
        vectors++;
        if ({busy, at_target, fault, cmd_ready, duty} !== {4'b0101, expd}) begin
            $display("FAIL %s: busy/at/fault/rdy/duty=%b%b%b%b/%h expected 0101/%h",
                     name, busy, at_target, fault, cmd_ready, duty, expd);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({cmd_ready, busy, at_target, fault, period_end, duty} !== {5'b10100, 8'h00}) begin
            $display("FAIL reset_state: got %b%b%b%b%b/%h expected 10100/00",
                     cmd_ready, busy, at_target, fault, period_end, duty);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_duty = 0;
    endtask

    task automatic test_ramp_up();
        issue(8'h20, 4'd4);
        push_ramp(8'h20, 4);
        drain(99, 300);
        check_idle("ramp_up_done", 8'h20);
    endtask

    task automatic test_step_limits();
        issue(8'h1E, 4'd8);
        push_ramp(8'h1E, 8);
        drain(99, 300);
        check_idle("no_undershoot", 8'h1E);
        issue(8'hF8, 4'd15);
        push_ramp(8'hF8, 15);
        drain(99, 300);
        issue(8'hFF, 4'd15);
        push_ramp(8'hFF, 15);
        drain(99, 300);
        check_idle("sat_high", 8'hFF);
        issue(8'h03, 4'd15);
        push_ramp(8'h03, 15);
        drain(99, 300);
        issue(8'h00, 4'd0);
        push_ramp(8'h00, 0);
        drain(99, 300);
        check_idle("sat_low_step0", 8'h00);
    endtask

    task automatic test_retarget();
        int cyc;
        issue(8'h40, 4'd4);
        push_ramp(8'h40, 4);
        drain(4, 300);
        exp_q.delete();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!period_end && cyc < 300);
        cmd_valid  = 1'b1;
        cmd_target = 8'h08;
        cmd_step   = 4'd4;
        @(posedge clk);
        #1;
        vectors++;
        if (duty !== 8'h10 || busy !== 1'b1) begin
            $display("FAIL retarget_no_step: duty=%h busy=%b expected 10/1", duty, busy);
            miscompares++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        push_ramp(8'h08, 4);
        drain(99, 300);
        check_idle("retarget_done", 8'h08);
    endtask

    task automatic test_estop();
        issue(8'h80, 4'd4);
        push_ramp(8'h80, 4);
        drain(1, 300);
        exp_q.delete();
        repeat (37) @(negedge clk);
        estop = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({cmd_ready, busy, at_target, fault, duty} !== {4'b0001, 8'h00}) begin
            $display("FAIL estop_entry: rdy/busy/at/fault/duty=%b%b%b%b/%h expected 0001/00",
                     cmd_ready, busy, at_target, fault, duty);
            miscompares++;
        end
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_target = 8'h50;
        cmd_step   = 4'd4;
        repeat (300) @(negedge clk);
        vectors++;
        if ({cmd_ready, fault, duty} !== {2'b01, 8'h00}) begin
            $display("FAIL estop_ignores_cmd: rdy/fault/duty=%b%b/%h expected 01/00",
                     cmd_ready, fault, duty);
            miscompares++;
        end
        cmd_valid = 1'b0;
        estop     = 1'b0;
        @(posedge clk);
        #1;
        check_idle("estop_release", 8'h00);
        mdl_duty = 0;
    endtask

    task automatic test_prescale_and_reset();
        logic [7:0] last;
        int cyc;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_duty = 0;
        issue(8'h0C, 4'd4);
        last = duty3;
        cyc  = 0;
        while (duty3 === last && cyc < 800) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (duty3 !== 8'h04) begin
            $display("FAIL pps3_first: duty3=%h expected 04 after %0d clk", duty3, cyc);
            miscompares++;
        end
        last = duty3;
        cyc  = 0;
        while (duty3 === last && cyc < 800) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (cyc != 768 || duty3 !== 8'h08 || busy3 !== 1'b1) begin
            $display("FAIL pps3_spacing: %0d clk duty3=%h busy3=%b expected 768 08 1",
                     cyc, duty3, busy3);
            miscompares++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready3, busy3, at_target3, fault3, period_end3, duty3} !== {5'b10100, 8'h00} ||
            {cmd_ready, busy, at_target, fault, period_end, duty} !== {5'b10100, 8'h00}) begin
            $display("FAIL async_reset: dut3 %b%b%b%b%b/%h dut %b%b%b%b%b/%h expected 10100/00",
                     cmd_ready3, busy3, at_target3, fault3, period_end3, duty3,
                     cmd_ready, busy, at_target, fault, period_end, duty);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy3, at_target3, duty3} !== {2'b01, 8'h00}) begin
            $display("FAIL post_reset_idle: busy3/at3/duty3=%b%b/%h expected 01/00",
                     busy3, at_target3, duty3);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_step_limits();
        test_retarget();
        test_estop();
        test_prescale_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
